// File: rtl/ariane_pkg.sv
// Shared core package slice: dcache port request/response types seen by the bridge.
package ariane_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 20;
    localparam int unsigned TRANS_ID_BITS      = 4;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [1:0]                    data_size;
        logic [TRANS_ID_BITS-1:0]      data_id;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_t;

    typedef struct packed {
        logic                     data_gnt;
        logic                     data_rvalid;
        logic [TRANS_ID_BITS-1:0] data_rid;
        logic [XLEN-1:0]          data_rdata;
    } dcache_rsp_t;

endpackage

// File: rtl/axi_dcache_bridge_pkg.sv
// Local types and helpers for the AXI-to-dcache bridge.
package axi_dcache_bridge_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    // Natural access size for a strobe; irregular patterns fall back to the full bus width.
    function automatic logic [1:0] strb_to_size(input logic [7:0] strb, input int unsigned nbytes);
        logic [1:0] sz;
        sz = (nbytes == 8) ? 2'd3 : 2'd2;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbytes) begin
                if (strb == (8'h01 << i)) sz = 2'd0;
                if ((i % 2 == 0) && (i + 1 < nbytes) && (strb == (8'h03 << i))) sz = 2'd1;
                if ((i % 4 == 0) && (i + 3 < nbytes) && (strb == (8'h0F << i))) sz = 2'd2;
            end
        end
        return sz;
    endfunction

endpackage

// File: rtl/axi_dcache_bridge_fifo.sv
// Small circular FIFO used for the buffered R and B channels.
module bridge_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

    overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/axi_dcache_bridge.sv
// AXI4 single-beat slave turning AR/AW/W traffic into dcache load/store port requests.
module axi_dcache_bridge
    import ariane_pkg::*;
    import axi_dcache_bridge_pkg::*;
#(
    parameter int unsigned IdWidth    = TRANS_ID_BITS,
    parameter int unsigned IndexWidth = DCACHE_INDEX_WIDTH,
    parameter int unsigned TagWidth   = DCACHE_TAG_WIDTH,
    parameter int unsigned DataWidth  = XLEN,
    parameter int unsigned RdDepth    = 4,
    parameter int unsigned BDepth     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           aw_valid,
    output logic                           aw_ready,
    input  logic [IdWidth-1:0]             aw_id,
    input  logic [TagWidth+IndexWidth-1:0] aw_addr,
    input  logic [7:0]                     aw_len,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [DataWidth-1:0]           w_data,
    input  logic [DataWidth/8-1:0]         w_strb,
    output logic                           b_valid,
    input  logic                           b_ready,
    output logic [IdWidth-1:0]             b_id,
    output logic [1:0]                     b_resp,
    input  logic                           ar_valid,
    output logic                           ar_ready,
    input  logic [IdWidth-1:0]             ar_id,
    input  logic [TagWidth+IndexWidth-1:0] ar_addr,
    input  logic [7:0]                     ar_len,
    output logic                           r_valid,
    input  logic                           r_ready,
    output logic [IdWidth-1:0]             r_id,
    output logic [DataWidth-1:0]           r_data,
    output logic [1:0]                     r_resp,
    output logic                           r_last,
    output dcache_req_t                    wr_req_o,
    input  dcache_rsp_t                    wr_rsp_i,
    output dcache_req_t                    rd_req_o,
    input  dcache_rsp_t                    rd_rsp_i
);

    localparam int unsigned AddrWidth = TagWidth + IndexWidth;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffBits   = $clog2(StrbWidth);
    localparam int unsigned CntW      = $clog2(RdDepth + 1);
    localparam int unsigned RWidth    = IdWidth + DataWidth + 2;
    localparam int unsigned BWidth    = IdWidth + 2;

    logic                 aw_held_q, aw_held_d, aw_err_q, w_held_q, w_held_d;
    logic [IdWidth-1:0]   aw_id_q;
    logic [AddrWidth-1:0] aw_addr_q;
    logic [DataWidth-1:0] w_data_q;
    logic [StrbWidth-1:0] w_strb_q;
    logic [CntW-1:0]      credits_q, credits_d;
    logic                 rd_tag_q, rd_tag_d;
    logic [TagWidth-1:0]  tag_q;

    logic wr_issue, wr_bypass, wr_done, b_full, b_empty;
    logic raw_hazard, ar_ok, ar_len_err, ar_hs;
    logic r_push, r_pop, r_full, r_empty;
    logic [RWidth-1:0] r_din, r_dout;
    logic [BWidth-1:0] b_din, b_dout;
    logic unused_rsp;

    assign aw_ready = !aw_held_q;
    assign w_ready  = !w_held_q;

    // Zero-strobe and burst writes are answered locally and never reach the cache.
    assign wr_issue  = aw_held_q && w_held_q && !b_full;
    assign wr_bypass = aw_err_q || (w_strb_q == '0);
    assign wr_done   = wr_issue && (wr_bypass || wr_rsp_i.data_gnt);
    assign b_din     = {aw_id_q, aw_err_q ? SLVERR : OKAY};

    always_comb begin
        wr_req_o               = '0;
        wr_req_o.address_index = aw_addr_q[IndexWidth-1:0];
        wr_req_o.address_tag   = aw_addr_q[AddrWidth-1:IndexWidth];
        wr_req_o.data_wdata    = w_data_q;
        wr_req_o.data_req      = wr_issue && !wr_bypass;
        wr_req_o.data_we       = 1'b1;
        wr_req_o.data_be       = w_strb_q;
        wr_req_o.data_size     = strb_to_size(8'(w_strb_q), StrbWidth);
        wr_req_o.data_id       = aw_id_q;
    end

    assign aw_held_d = wr_done ? 1'b0 : (aw_held_q || aw_valid);
    assign w_held_d  = wr_done ? 1'b0 : (w_held_q || w_valid);

    // Reads to the word a pending write targets wait until that write is granted.
    assign raw_hazard = aw_held_q && (aw_addr_q[AddrWidth-1:OffBits] == ar_addr[AddrWidth-1:OffBits]);
    assign ar_ok      = (credits_q < CntW'(RdDepth)) && !rd_tag_q && !raw_hazard;
    assign ar_len_err = (ar_len != 8'd0);
    assign ar_ready   = ar_ok && (ar_len_err ? !rd_rsp_i.data_rvalid : rd_rsp_i.data_gnt);
    assign ar_hs      = ar_valid && ar_ready;
    assign rd_tag_d   = ar_hs && !ar_len_err;

    always_comb begin
        rd_req_o               = '0;
        rd_req_o.address_index = ar_addr[IndexWidth-1:0];
        rd_req_o.address_tag   = tag_q;
        rd_req_o.data_req      = ar_valid && ar_ok && !ar_len_err;
        rd_req_o.data_be       = '1;
        rd_req_o.data_size     = 2'(OffBits);
        rd_req_o.data_id       = ar_id;
        rd_req_o.tag_valid     = rd_tag_q;
    end

    assign r_pop     = r_valid && r_ready;
    assign r_push    = rd_rsp_i.data_rvalid || (ar_hs && ar_len_err);
    assign r_din     = rd_rsp_i.data_rvalid ? {rd_rsp_i.data_rid, rd_rsp_i.data_rdata, OKAY}
                                            : {ar_id, {DataWidth{1'b0}}, SLVERR};
    assign credits_d = credits_q + CntW'(ar_hs) - CntW'(r_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            aw_err_q  <= 1'b0;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            credits_q <= '0;
            rd_tag_q  <= 1'b0;
            tag_q     <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            credits_q <= credits_d;
            rd_tag_q  <= rd_tag_d;
            if (aw_valid && aw_ready) begin
                aw_id_q   <= aw_id;
                aw_addr_q <= aw_addr;
                aw_err_q  <= (aw_len != 8'd0);
            end
            if (w_valid && w_ready) begin
                w_data_q <= w_data;
                w_strb_q <= w_strb;
            end
            if (rd_tag_d) tag_q <= ar_addr[AddrWidth-1:IndexWidth];
        end
    end

    bridge_fifo #(.Width(RWidth), .Depth(RdDepth)) i_r_fifo (
        .clk_i, .rst_ni, .push_i(r_push), .data_i(r_din), .pop_i(r_pop),
        .data_o(r_dout), .full_o(r_full), .empty_o(r_empty)
    );

    bridge_fifo #(.Width(BWidth), .Depth(BDepth)) i_b_fifo (
        .clk_i, .rst_ni, .push_i(wr_done), .data_i(b_din), .pop_i(b_valid && b_ready),
        .data_o(b_dout), .full_o(b_full), .empty_o(b_empty)
    );

    assign r_valid = !r_empty;
    assign {r_id, r_data, r_resp} = r_dout;
    assign r_last  = 1'b1;
    assign b_valid = !b_empty;
    assign {b_id, b_resp} = b_dout;

    assign unused_rsp = ^{wr_rsp_i.data_rvalid, wr_rsp_i.data_rid, wr_rsp_i.data_rdata, r_full};

endmodule

// File: tb/tb_axi_dcache_bridge.sv
// Scoreboard bench for axi_dcache_bridge with behavioural dcache load/store port models.
module tb_axi_dcache_bridge;
    import ariane_pkg::*;
    import axi_dcache_bridge_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [3:0]  aw_id, b_id, ar_id, r_id, w_strb;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [7:0]  aw_len, ar_len;
    logic [1:0]  b_resp, r_resp;
    dcache_req_t wr_req, rd_req;
    dcache_rsp_t wr_rsp, rd_rsp;

    logic        wr_gnt = 1'b0, m_rvalid = 1'b0;
    logic [3:0]  m_rid = '0;
    logic [31:0] m_rdata = '0, rd_a;
    logic        rd_gnt_en, rd_ret_en;
    int          wcnt = 0, wr_grants = 0, rd_grants = 0, cyc = 0, last_wgnt_cyc = 0;
    int          first_pop_cyc = 0;
    bit          arm_pop = 1'b0;
    int          total = 0, bad = 0;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; logic [1:0] size; } wr_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    wr_exp_t exp_wr[$];
    r_exp_t  exp_r[$];
    b_exp_t  exp_b[$];
    logic [11:0] pidx[$];
    logic [3:0]  pid[$], qid[$];
    logic [31:0] qdata[$];

    assign wr_rsp = {wr_gnt, 1'b0, 4'h0, 32'h0};
    assign rd_rsp = {rd_req.data_req & rd_gnt_en, m_rvalid, m_rid, m_rdata};

    axi_dcache_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .wr_req_o(wr_req), .wr_rsp_i(wr_rsp), .rd_req_o(rd_req), .rd_rsp_i(rd_rsp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return 32'hA500_0000 ^ (a * 32'd7);
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Store port: grants after the request has been seen for two extra cycles.
    always @(negedge clk_i) begin
        wr_gnt = 1'b0;
        if (!rst_ni) wcnt = 0;
        else if (wr_req.data_req) begin
            if (wcnt == 2) begin
                wr_gnt = 1'b1;
                wcnt = 0;
                wr_grants++;
                last_wgnt_cyc = cyc;
                if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    wr_exp_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", {wr_req.address_tag, wr_req.address_index}, e.addr);
                    chk("wr_data", wr_req.data_wdata, e.data);
                    chk("wr_be", wr_req.data_be, e.be);
                    chk("wr_size", wr_req.data_size, e.size);
                    chk("wr_we", wr_req.data_we, 1);
                end
            end else wcnt++;
        end else wcnt = 0;
    end

    // Load port: grant on request, full address assembled in the tag cycle, returns in order.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            pidx.delete(); pid.delete(); qid.delete(); qdata.delete();
            m_rvalid = 1'b0;
        end else begin
            if (rd_req.tag_valid) begin
                if (pidx.size() == 0) chk("rd_tag_extra", 1, 0);
                else begin
                    rd_a = {rd_req.address_tag, pidx.pop_front()};
                    qid.push_back(pid.pop_front());
                    qdata.push_back(rdata_of(rd_a));
                end
            end
            if (rd_req.data_req && rd_gnt_en) begin
                rd_grants++;
                pidx.push_back(rd_req.address_index);
                pid.push_back(rd_req.data_id);
                chk("rd_size", rd_req.data_size, 2);
                chk("rd_attr", {rd_req.data_we, rd_req.data_be}, 5'h0F);
            end
            m_rvalid = 1'b0;
            if (rd_ret_en && qid.size() > 0) begin
                m_rvalid = 1'b1;
                m_rid    = qid.pop_front();
                m_rdata  = qdata.pop_front();
            end
        end
    end

    always @(negedge clk_i) begin
        if (r_valid && r_ready) begin
            if (arm_pop) begin first_pop_cyc = cyc; arm_pop = 1'b0; end
            if (exp_r.size() == 0) chk("r_extra", 1, 0);
            else begin
                r_exp_t e;
                e = exp_r.pop_front();
                chk("r_id", r_id, e.id);
                chk("r_data", r_data, e.data);
                chk("r_resp", r_resp, e.resp);
                chk("r_last", r_last, 1);
            end
        end
        if (b_valid && b_ready) begin
            if (exp_b.size() == 0) chk("b_extra", 1, 0);
            else begin
                b_exp_t e;
                e = exp_b.pop_front();
                chk("b_id", b_id, e.id);
                chk("b_resp", b_resp, e.resp);
            end
        end
    end

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        w_valid = 1; w_data = d; w_strb = s;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk_i); #1; ok = w_ready; end
        if (!ok) chk("w_timeout", 0, 1);
        @(posedge clk_i); #1; w_valid = 0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        bit ok = 0;
        aw_valid = 1; aw_id = id; aw_addr = a; aw_len = len;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk_i); #1; ok = aw_ready; end
        if (!ok) chk("aw_timeout", 0, 1);
        @(posedge clk_i); #1; aw_valid = 0;
    endtask

    task automatic wait_ar_acc(output int acc);
        bit ok = 0;
        acc = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (ar_ready) begin ok = 1; acc = cyc; end
        end
        if (!ok) chk("ar_timeout", 0, 1);
        @(posedge clk_i); #1; ar_valid = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, output int acc);
        ar_valid = 1; ar_id = id; ar_addr = a; ar_len = len;
        wait_ar_acc(acc);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i); #1;
            ok = (exp_r.size() == 0) && (exp_b.size() == 0) && (exp_wr.size() == 0);
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk_i); #1;
    endtask

    logic [3:0] st_tab [6] = '{4'b0100, 4'b1100, 4'b0110, 4'b0011, 4'b0001, 4'b0000};
    logic [1:0] sz_tab [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0};

    initial begin
        int acc, g0, c0;
        bit seen;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
        w_valid = 0; w_data = 0; w_strb = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0;
        b_ready = 1; r_ready = 1; rd_gnt_en = 1; rd_ret_en = 1;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_wr_req", wr_req.data_req, 0);
        chk("rst_tag_valid", rd_req.tag_valid, 0);
        @(posedge clk_i); #1; rst_ni = 1;
        @(negedge clk_i); #1;
        chk("aw_ready_init", aw_ready, 1);
        chk("w_ready_init", w_ready, 1);
        @(posedge clk_i); #1;

        // single write, W ahead of AW
        exp_wr.push_back('{32'h100, 32'hDEADBEEF, 4'hF, 2'd2});
        exp_b.push_back('{4'd3, OKAY});
        send_w(32'hDEADBEEF, 4'hF);
        send_aw(4'd3, 32'h100, 8'd0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk_i); #1; seen = wr_gnt; end
        chk("wr_gnt_seen", seen, 1);
        @(negedge clk_i); #1;
        chk("b_latency", b_valid, 1);
        wait_idle();

        // four reads fill the credits, fifth stalls until the first R pop
        r_ready = 0;
        g0 = rd_grants;
        for (int i = 0; i < 4; i++) begin
            exp_r.push_back('{4'(i), rdata_of(32'h1000 + 32'(i * 8)), OKAY});
            send_ar(4'(i), 32'h1000 + 32'(i * 8), 8'd0, acc);
        end
        chk("rd_grants4", rd_grants - g0, 4);
        exp_r.push_back('{4'd4, rdata_of(32'h1040), OKAY});
        ar_valid = 1; ar_id = 4'd4; ar_addr = 32'h1040; ar_len = 0;
        seen = 0;
        repeat (6) begin @(negedge clk_i); #1; seen |= ar_ready; end
        chk("ar_credit_stall", seen, 0);
        @(posedge clk_i); #1;
        arm_pop = 1'b1; r_ready = 1;
        wait_ar_acc(acc);
        chk("ar_after_pop", acc, first_pop_cyc + 1);
        wait_idle();

        // read-after-write hazard
        exp_b.push_back('{4'd6, OKAY});
        exp_wr.push_back('{32'h200, 32'h1234_5678, 4'hF, 2'd2});
        send_aw(4'd6, 32'h200, 8'd0);
        c0 = cyc;
        exp_r.push_back('{4'd7, rdata_of(32'h204), OKAY});
        send_ar(4'd7, 32'h204, 8'd0, acc);
        chk("raw_other_word", acc, c0);
        exp_r.push_back('{4'd8, rdata_of(32'h200), OKAY});
        ar_valid = 1; ar_id = 4'd8; ar_addr = 32'h200; ar_len = 0;
        seen = 0;
        repeat (4) begin @(negedge clk_i); #1; seen |= ar_ready; end
        chk("raw_block", seen, 0);
        @(posedge clk_i); #1;
        send_w(32'h1234_5678, 4'hF);
        wait_ar_acc(acc);
        chk("raw_release", acc, last_wgnt_cyc + 1);
        wait_idle();

        // strobe-to-size table, zero strobe answered locally
        for (int i = 0; i < 6; i++) begin
            g0 = wr_grants;
            if (st_tab[i] != 4'b0) exp_wr.push_back('{32'h300 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), st_tab[i], sz_tab[i]});
            exp_b.push_back('{4'(i), OKAY});
            send_w(32'hC0DE_0000 + 32'(i), st_tab[i]);
            send_aw(4'(i), 32'h300 + 32'(i * 4), 8'd0);
            wait_idle();
            chk("strb_req_count", wr_grants - g0, (st_tab[i] != 4'b0) ? 1 : 0);
        end

        // burst requests rejected without touching the cache
        g0 = wr_grants;
        exp_b.push_back('{4'd9, SLVERR});
        send_w(32'h5555_AAAA, 4'hF);
        send_aw(4'd9, 32'h400, 8'd3);
        wait_idle();
        chk("aw_burst_no_req", wr_grants - g0, 0);
        g0 = rd_grants;
        exp_r.push_back('{4'd10, 32'h0, SLVERR});
        send_ar(4'd10, 32'h500, 8'd1, acc);
        wait_idle();
        chk("ar_burst_no_req", rd_grants - g0, 0);

        // reset with two reads in flight drops them
        rd_ret_en = 0;
        send_ar(4'd11, 32'h600, 8'd0, acc);
        send_ar(4'd12, 32'h608, 8'd0, acc);
        rst_ni = 0;
        @(negedge clk_i); #1;
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        chk("mid_rst_tag_valid", rd_req.tag_valid, 0);
        chk("mid_rst_rd_req", rd_req.data_req, 0);
        @(posedge clk_i); #1;
        rst_ni = 1; rd_ret_en = 1;
        seen = 0;
        repeat (8) begin @(negedge clk_i); #1; seen |= r_valid; end
        chk("no_r_after_rst", seen, 0);
        chk("aw_ready_after_rst", aw_ready, 1);
        @(posedge clk_i); #1;
        r_ready = 0;
        for (int i = 0; i < 4; i++) begin
            exp_r.push_back('{4'(i), rdata_of(32'h700 + 32'(i * 8)), OKAY});
            send_ar(4'(i), 32'h700 + 32'(i * 8), 8'd0, acc);
        end
        r_ready = 1;
        wait_idle();

        chk("queues_drained", 64'(exp_r.size() + exp_b.size() + exp_wr.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
